// File: rtl/result_deskew.sv
// Realigns the systolic array's staggered lane results into one packed row, tags it with a
// row index, flags frame completion after ROWS rows and reports lane misalignment.
module result_deskew #(
   parameter int DATA_WIDTH = 16,
   parameter int N          = 4,
   parameter int ROWS       = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clr,
   input  logic [N-1:0]                 lane_valid,
   input  logic [N*DATA_WIDTH-1:0]      lane_data,
   output logic                         out_valid,
   output logic [N*DATA_WIDTH-1:0]      out_data,
   output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row,
   output logic                         frame_done,
   output logic                         busy,
   output logic                         skew_err
);

   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

   typedef enum logic {S_IDLE, S_COLLECT} state_t;

   logic [N-1:0]            al_vld;
   logic [N*DATA_WIDTH-1:0] al_dat;

   // Lane i is delayed N-1-i cycles so every lane lines up with lane N-1.
   for (genvar i = 0; i < N; i++) begin : g_lane
      localparam int D = N - 1 - i;
      if (D == 0) begin : g_direct
         assign al_vld[i]                           = lane_valid[i];
         assign al_dat[i*DATA_WIDTH +: DATA_WIDTH] = lane_data[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_dly
         logic [D-1:0]          vld_q;
         logic [DATA_WIDTH-1:0] dat_q [D];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               vld_q <= '0;
               for (int k = 0; k < D; k++) dat_q[k] <= '0;
            end else begin
               vld_q[0] <= lane_valid[i] & ~clr;
               if (lane_valid[i]) dat_q[0] <= lane_data[i*DATA_WIDTH +: DATA_WIDTH];
               for (int k = 1; k < D; k++) begin
                  vld_q[k] <= vld_q[k-1] & ~clr;
                  dat_q[k] <= dat_q[k-1];
               end
            end
         end

         assign al_vld[i]                           = vld_q[D-1];
         assign al_dat[i*DATA_WIDTH +: DATA_WIDTH] = dat_q[D-1];
      end
   end

   state_t                  state_q;
   logic [RW-1:0]           row_cnt_q;
   logic                    out_valid_q;
   logic [N*DATA_WIDTH-1:0] out_data_q;
   logic [RW-1:0]           out_row_q;
   logic                    frame_done_q;
   logic                    busy_q;
   logic                    skew_err_q;

   logic row_full, row_none, last_row;
   assign row_full = &al_vld;
   assign row_none = ~|al_vld;
   assign last_row = (row_cnt_q == RW'(ROWS - 1));

   // busy stays high through the cycle that presents the final row of a frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         row_cnt_q    <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_row_q    <= '0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
         skew_err_q   <= 1'b0;
      end else if (clr) begin
         state_q      <= S_IDLE;
         row_cnt_q    <= '0;
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
         skew_err_q   <= 1'b0;
      end else begin
         out_valid_q  <= row_full;
         frame_done_q <= 1'b0;
         if (!row_full && !row_none) skew_err_q <= 1'b1;
         if (row_full) begin
            out_data_q <= al_dat;
            out_row_q  <= row_cnt_q;
            case (state_q)
               S_IDLE: begin
                  if (ROWS == 1) begin
                     frame_done_q <= 1'b1;
                     busy_q       <= 1'b0;
                  end else begin
                     row_cnt_q <= RW'(1);
                     state_q   <= S_COLLECT;
                     busy_q    <= 1'b1;
                  end
               end
               S_COLLECT: begin
                  busy_q <= 1'b1;
                  if (last_row) begin
                     frame_done_q <= 1'b1;
                     row_cnt_q    <= '0;
                     state_q      <= S_IDLE;
                  end else begin
                     row_cnt_q <= row_cnt_q + RW'(1);
                  end
               end
            endcase
         end else begin
            busy_q <= (state_q == S_COLLECT);
         end
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_row    = out_row_q;
   assign frame_done = frame_done_q;
   assign busy       = busy_q;
   assign skew_err   = skew_err_q;

endmodule
